// File: rtl/wdt_pkg.sv
// ============================================================================
// Module      : wdt_pkg
// Description : Shared register offsets, bit positions and types for the
//               multi-channel watchdog register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wdt_pkg;

    localparam logic [11:0] OFS_LOAD  = 12'h000;
    localparam logic [11:0] OFS_VALUE = 12'h004;
    localparam logic [11:0] OFS_CTL   = 12'h008;
    localparam logic [11:0] OFS_ICR   = 12'h00C;
    localparam logic [11:0] OFS_RIS   = 12'h400;
    localparam logic [11:0] OFS_MIS   = 12'h404;
    localparam logic [11:0] OFS_TEST  = 12'h418;
    localparam logic [11:0] OFS_CAUSE = 12'h41C;
    localparam logic [11:0] OFS_LOCK  = 12'hC00;
    localparam logic [11:0] CH_STRIDE = 12'h020;

    localparam logic [31:0] DEFAULT_LOCK_KEY = 32'h1ACC_E551;

    localparam int CTL_INTEN_BIT  = 0;
    localparam int CTL_RESEN_BIT  = 1;
    localparam int TEST_TEST_BIT  = 0;
    localparam int TEST_STALL_BIT = 8;

    typedef struct packed {
        logic resen;
        logic inten;
    } ctl_t;

endpackage

`default_nettype wire

// File: rtl/wdt_channel.sv
// ============================================================================
// Module      : wdt_channel
// Description : One watchdog channel: down-counter, LOAD, CTL and raw
//               interrupt status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wdt_channel
    import wdt_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             tick_run,
    input  logic             load_we,
    input  logic             ctl_we,
    input  logic             icr_we,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] load,
    output ctl_t             ctl,
    output logic             ris,
    output logic             timeout,
    output logic             rst_req
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_load;
    ctl_t             r_ctl;
    logic             r_ris;
    logic             w_count_en;
    logic             w_timeout;

    assign w_count_en = r_ctl.inten & tick_run;
    // A LOAD write in the same cycle pre-empts the timeout entirely.
    assign w_timeout  = w_count_en & (r_count == '0) & ~load_we;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_count <= '1;
            r_load  <= '1;
            r_ctl   <= '0;
            r_ris   <= 1'b0;
        end else begin
            if (load_we) begin
                r_load  <= wdata;
                r_count <= wdata;
            end else if (w_timeout) begin
                r_count <= r_load;
            end else if (w_count_en) begin
                r_count <= r_count - 1'b1;
            end

            if (ctl_we) begin
                r_ctl.inten <= r_ctl.inten | wdata[CTL_INTEN_BIT];
                r_ctl.resen <= wdata[CTL_RESEN_BIT];
            end

            if (w_timeout) begin
                r_ris <= 1'b1;
            end else if (load_we || icr_we) begin
                r_ris <= 1'b0;
            end
        end
    end

    assign value   = r_count;
    assign load    = r_load;
    assign ctl     = r_ctl;
    assign ris     = r_ris;
    assign timeout = w_timeout;
    // Armed level: the next timeout of this channel requests a system reset.
    assign rst_req = r_ris & r_ctl.resen;

endmodule

`default_nettype wire

// File: rtl/wdt_reg_bank_mc.sv
// ============================================================================
// Module      : wdt_reg_bank_mc
// Description : Multi-channel watchdog register bank with lock key, TEST/STALL
//               control and reset cause. Optional macro: WDT_SLVERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wdt_reg_bank_mc
    import wdt_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] LOCK_KEY = DEFAULT_LOCK_KEY
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [11:0]       paddr,
    input  logic [31:0]       pwdata,
    input  logic              tick,
    input  logic              dbg_halt,
    output logic [31:0]       prdata,
    output logic [NUM_CH-1:0] irq,
    output logic              wdt_rst,
    output logic              lock
`ifdef WDT_SLVERR_EN
    ,
    output logic              pslverr
`endif
);

    logic [CNT_W-1:0]  w_value [NUM_CH];
    logic [CNT_W-1:0]  w_load  [NUM_CH];
    ctl_t              w_ctl   [NUM_CH];
    logic [NUM_CH-1:0] w_ris;
    logic [NUM_CH-1:0] w_inten;
    logic [NUM_CH-1:0] w_timeout;
    logic [NUM_CH-1:0] w_rst_arm;
    logic [NUM_CH-1:0] w_rst_fire;
    logic [NUM_CH-1:0] w_sel_load;
    logic [NUM_CH-1:0] w_sel_value;
    logic [NUM_CH-1:0] w_sel_ctl;
    logic [NUM_CH-1:0] w_sel_icr;
    logic [NUM_CH-1:0] w_load_we;
    logic [NUM_CH-1:0] w_ctl_we;
    logic [NUM_CH-1:0] w_icr_we;
    logic              w_sel_ris;
    logic              w_sel_mis;
    logic              w_sel_test;
    logic              w_sel_cause;
    logic              w_sel_lock;
    logic              w_tick_run;
    logic [31:0]       w_test_rd;

    logic              r_test;
    logic              r_stall;
    logic              r_lock;
    logic [NUM_CH-1:0] r_cause;
    logic              r_wdt_rst;

    always_comb begin
        w_sel_load  = '0;
        w_sel_value = '0;
        w_sel_ctl   = '0;
        w_sel_icr   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_sel_load[ch]  = (paddr == 12'(ch) * CH_STRIDE + OFS_LOAD);
            w_sel_value[ch] = (paddr == 12'(ch) * CH_STRIDE + OFS_VALUE);
            w_sel_ctl[ch]   = (paddr == 12'(ch) * CH_STRIDE + OFS_CTL);
            w_sel_icr[ch]   = (paddr == 12'(ch) * CH_STRIDE + OFS_ICR);
        end
    end

    assign w_sel_ris   = (paddr == OFS_RIS);
    assign w_sel_mis   = (paddr == OFS_MIS);
    assign w_sel_test  = (paddr == OFS_TEST);
    assign w_sel_cause = (paddr == OFS_CAUSE);
    assign w_sel_lock  = (paddr == OFS_LOCK);

    assign w_load_we  = w_sel_load & {NUM_CH{wr_en & ~r_lock}};
    assign w_ctl_we   = w_sel_ctl  & {NUM_CH{wr_en & ~r_lock}};
    assign w_icr_we   = w_sel_icr  & {NUM_CH{wr_en & ~r_lock}};
    assign w_tick_run = tick & ~(r_stall & dbg_halt);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        wdt_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .pclk     (pclk),
            .presetn  (presetn),
            .tick_run (w_tick_run),
            .load_we  (w_load_we[g]),
            .ctl_we   (w_ctl_we[g]),
            .icr_we   (w_icr_we[g]),
            .wdata    (pwdata[CNT_W-1:0]),
            .value    (w_value[g]),
            .load     (w_load[g]),
            .ctl      (w_ctl[g]),
            .ris      (w_ris[g]),
            .timeout  (w_timeout[g]),
            .rst_req  (w_rst_arm[g])
        );
        assign w_inten[g] = w_ctl[g].inten;
    end

    // TEST mode keeps the interrupt path alive but blocks the reset request.
    assign w_rst_fire = w_timeout & w_rst_arm & {NUM_CH{~r_test}};

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_test    <= 1'b0;
            r_stall   <= 1'b0;
            r_lock    <= 1'b0;
            r_cause   <= '0;
            r_wdt_rst <= 1'b0;
        end else begin
            if (wr_en && w_sel_test) begin
                r_test <= pwdata[TEST_TEST_BIT];
                if (!r_lock) begin
                    r_stall <= pwdata[TEST_STALL_BIT];
                end
            end
            if (wr_en && w_sel_lock) begin
                r_lock <= (pwdata != LOCK_KEY);
            end
            r_cause   <= r_cause | w_rst_fire;
            r_wdt_rst <= |w_rst_fire;
        end
    end

    always_comb begin
        w_test_rd                 = '0;
        w_test_rd[TEST_TEST_BIT]  = r_test;
        w_test_rd[TEST_STALL_BIT] = r_stall;
    end

    always_comb begin
        prdata = '0;
        if (rd_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_sel_load[ch])  prdata = 32'(w_load[ch]);
                if (w_sel_value[ch]) prdata = 32'(w_value[ch]);
                if (w_sel_ctl[ch])   prdata = 32'({w_ctl[ch].resen, w_ctl[ch].inten});
            end
            if (w_sel_ris)   prdata = 32'(w_ris);
            if (w_sel_mis)   prdata = 32'(w_ris & w_inten);
            if (w_sel_test)  prdata = w_test_rd;
            if (w_sel_cause) prdata = 32'(r_cause);
            if (w_sel_lock)  prdata = {31'b0, r_lock};
        end
    end

`ifdef WDT_SLVERR_EN
    logic w_mapped;
    logic w_ro_wr;
    logic w_locked_wr;

    assign w_mapped    = |{w_sel_load, w_sel_value, w_sel_ctl, w_sel_icr,
                           w_sel_ris, w_sel_mis, w_sel_test, w_sel_cause, w_sel_lock};
    assign w_ro_wr     = wr_en & (|w_sel_value | w_sel_ris | w_sel_mis | w_sel_cause);
    assign w_locked_wr = wr_en & r_lock & |{w_sel_load, w_sel_ctl, w_sel_icr};
    assign pslverr     = ((wr_en | rd_en) & ~w_mapped) | w_ro_wr | w_locked_wr;
`endif

    assign irq     = w_ris & w_inten;
    assign wdt_rst = r_wdt_rst;
    assign lock    = r_lock;

endmodule

`default_nettype wire

// File: tb/tb_wdt_reg_bank_mc.sv
// ============================================================================
// Module      : tb_wdt_reg_bank_mc
// Description : Self-checking bench for wdt_reg_bank_mc: directed steps, then
//               randomized traffic against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wdt_reg_bank_mc;

    localparam int          NCH = 4;
    localparam logic [31:0] KEY = 32'h1ACC_E551;

    logic           clk = 1'b0;
    logic           presetn;
    logic           wr_en;
    logic           rd_en;
    logic [11:0]    paddr;
    logic [31:0]    pwdata;
    logic           tick;
    logic           dbg_halt;
    logic [31:0]    prdata;
    logic [NCH-1:0] irq;
    logic           wdt_rst;
    logic           lock;
`ifdef WDT_SLVERR_EN
    logic           pslverr;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wdt_reg_bank_mc #(
        .NUM_CH (NCH),
        .CNT_W  (32)
    ) dut (
        .pclk     (clk),
        .presetn  (presetn),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .tick     (tick),
        .dbg_halt (dbg_halt),
        .prdata   (prdata),
        .irq      (irq),
        .wdt_rst  (wdt_rst),
        .lock     (lock)
`ifdef WDT_SLVERR_EN
        ,
        .pslverr  (pslverr)
`endif
    );

    // Behavioural model state
    logic [31:0]    m_cnt [NCH];
    logic [31:0]    m_ld  [NCH];
    logic [NCH-1:0] m_inten, m_resen, m_ris, m_cause;
    logic           m_test, m_stall, m_lock, m_rst;

    function automatic bit m_wr(input int a);
        return wr_en && (paddr == 12'(a));
    endfunction
    function automatic bit m_run();
        return tick && !(m_stall && dbg_halt);
    endfunction
    function automatic bit m_ldw(input int c);
        return m_wr(c * 32) && !m_lock;
    endfunction
    function automatic bit m_ctlw(input int c);
        return m_wr(c * 32 + 8) && !m_lock;
    endfunction
    function automatic bit m_icrw(input int c);
        return m_wr(c * 32 + 12) && !m_lock;
    endfunction
    function automatic bit m_to(input int c);
        return m_inten[c] && m_run() && (m_cnt[c] == 32'd0) && !m_ldw(c);
    endfunction

    always @(posedge clk) begin
        if (!presetn) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] <= 32'hFFFF_FFFF;
                m_ld[c]  <= 32'hFFFF_FFFF;
            end
            m_inten <= '0; m_resen <= '0; m_ris <= '0; m_cause <= '0;
            m_test  <= 1'b0; m_stall <= 1'b0; m_lock <= 1'b0; m_rst <= 1'b0;
        end else begin
            m_rst <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (m_ldw(c)) begin
                    m_ld[c]  <= pwdata;
                    m_cnt[c] <= pwdata;
                end else if (m_to(c)) begin
                    m_cnt[c] <= m_ld[c];
                end else if (m_inten[c] && m_run()) begin
                    m_cnt[c] <= m_cnt[c] - 32'd1;
                end
                if (m_ctlw(c)) begin
                    m_inten[c] <= m_inten[c] | pwdata[0];
                    m_resen[c] <= pwdata[1];
                end
                if (m_to(c))                     m_ris[c] <= 1'b1;
                else if (m_ldw(c) || m_icrw(c))  m_ris[c] <= 1'b0;
                if (m_to(c) && m_ris[c] && m_resen[c] && !m_test) begin
                    m_cause[c] <= 1'b1;
                    m_rst      <= 1'b1;
                end
            end
            if (m_wr(12'h418)) begin
                m_test <= pwdata[0];
                if (!m_lock) m_stall <= pwdata[8];
            end
            if (m_wr(12'hC00)) m_lock <= (pwdata != KEY);
        end
    end

    function automatic logic [31:0] m_read(input logic [11:0] a);
        for (int c = 0; c < NCH; c++) begin
            if (a == 12'(c * 32))     return m_ld[c];
            if (a == 12'(c * 32 + 4)) return m_cnt[c];
            if (a == 12'(c * 32 + 8)) return {30'b0, m_resen[c], m_inten[c]};
        end
        case (a)
            12'h400: return {28'b0, m_ris};
            12'h404: return {28'b0, m_ris & m_inten};
            12'h418: return {23'b0, m_stall, 7'b0, m_test};
            12'h41C: return {28'b0, m_cause};
            12'hC00: return {31'b0, m_lock};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("irq", 32'(irq), 32'(m_ris & m_inten));
        chk("wdt_rst", 32'(wdt_rst), 32'(m_rst));
        chk("lock", 32'(lock), 32'(m_lock));
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input bit t = 1'b0);
        wr_en = 1'b1; paddr = a; pwdata = d; tick = t;
        step();
        wr_en = 1'b0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    // Reads land on even times; posedges are on odd times, so no races.
    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        rd_en = 1'b1; paddr = a;
        #2;
        chk(tag, prdata, exp);
        rd_en = 1'b0;
    endtask

    task automatic rd_model(input string tag, input logic [11:0] a);
        rd_en = 1'b1; paddr = a;
        #2;
        chk(tag, prdata, m_read(a));
        rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL tb_timeout: simulation exceeded time bound");
        $fatal(1, "time bound expired");
    end

    initial begin
        logic [11:0] a;
        logic [31:0] d;
        int unsigned pick;

        presetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; paddr = '0; pwdata = '0;
        tick = 1'b0; dbg_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        presetn = 1'b1;

        // Reset values
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_wdt_rst", 32'(wdt_rst), 32'h0);
        chk("rst_lock", 32'(lock), 32'h0);
        for (int c = 0; c < NCH; c++) begin
            rd_chk($sformatf("rst_load%0d", c),  12'(c * 32),      32'hFFFF_FFFF);
            rd_chk($sformatf("rst_value%0d", c), 12'(c * 32 + 4),  32'hFFFF_FFFF);
            rd_chk($sformatf("rst_ctl%0d", c),   12'(c * 32 + 8),  32'h0);
            rd_chk($sformatf("rst_icr%0d", c),   12'(c * 32 + 12), 32'h0);
        end
        rd_chk("rst_ris",   12'h400, 32'h0);
        rd_chk("rst_mis",   12'h404, 32'h0);
        rd_chk("rst_test",  12'h418, 32'h0);
        rd_chk("rst_cause", 12'h41C, 32'h0);
        rd_chk("rst_lockr", 12'hC00, 32'h0);
        rd_chk("unmapped",  12'h200, 32'h0);

        // ch1 timeout and ICR
        wr(12'h020, 32'd5);
        wr(12'h028, 32'h1);
        ticks(5);
        rd_chk("ch1_value0", 12'h024, 32'd0);
        ticks(1);
        rd_chk("ch1_ris", 12'h400, 32'h2);
        chk("ch1_irq", 32'(irq), 32'h2);
        rd_chk("ch1_reload", 12'h024, 32'd5);
        wr(12'h02C, 32'h0);
        rd_chk("ch1_icr", 12'h400, 32'h0);

        // ch0 second timeout -> reset pulse
        wr(12'h000, 32'd2);
        wr(12'h008, 32'h3);
        ticks(3);
        rd_model("ch0_ris_first", 12'h400);
        ticks(2);
        chk("ch0_no_pulse_yet", 32'(wdt_rst), 32'h0);
        ticks(1);
        chk("ch0_pulse", 32'(wdt_rst), 32'h1);
        step();
        chk("ch0_pulse_end", 32'(wdt_rst), 32'h0);
        rd_chk("ch0_cause", 12'h41C, 32'h1);
        wr(12'h418, 32'h1);
        ticks(3);
        chk("ch0_test_nopulse", 32'(wdt_rst), 32'h0);
        wr(12'h418, 32'h0);

        // Lock
        wr(12'hC00, 32'h0);
        chk("locked", 32'(lock), 32'h1);
        wr(12'h040, 32'h10);
        rd_chk("locked_load", 12'h040, 32'hFFFF_FFFF);
        wr(12'hC00, KEY);
        chk("unlocked", 32'(lock), 32'h0);
        wr(12'h040, 32'h10);
        rd_chk("unlocked_load", 12'h040, 32'h10);

        // Sticky INTEN, STALL with dbg_halt
        wr(12'h048, 32'h1);
        wr(12'h048, 32'h0);
        rd_chk("inten_sticky", 12'h048, 32'h1);
        wr(12'h418, 32'h100);
        dbg_halt = 1'b1;
        ticks(3);
        rd_chk("stall_frozen", 12'h044, 32'h10);
        dbg_halt = 1'b0;
        ticks(3);
        rd_chk("stall_resume", 12'h044, 32'h0D);
        wr(12'h418, 32'h0);

        // ch3: ICR collides with timeout, LOAD collides with tick
        wr(12'h060, 32'h0);
        wr(12'h068, 32'h1);
        ticks(1);
        wr(12'h06C, 32'h0, 1'b1);
        rd_en = 1'b1; paddr = 12'h400; #2;
        chk("icr_vs_timeout", 32'(prdata[3]), 32'h1);
        rd_en = 1'b0;
        wr(12'h060, 32'h77, 1'b1);
        rd_chk("load_vs_tick", 12'h064, 32'h77);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 24);
            if (pick < 16) a = 12'((pick / 4) * 32 + (pick % 4) * 4);
            else begin
                case (pick)
                    16: a = 12'h400;
                    17: a = 12'h404;
                    18, 19: a = 12'h418;
                    20: a = 12'h41C;
                    21: a = 12'hC00;
                    22: a = 12'h200;
                    default: a = 12'h7F0;
                endcase
            end
            if (a < 12'h080 && a[4:0] == 5'd0) d = $urandom_range(0, 6);
            else if (a == 12'hC00) d = ($urandom_range(0, 3) != 0) ? KEY : $urandom;
            else d = $urandom;
            wr_en    = ($urandom_range(0, 2) == 0);
            paddr    = a;
            pwdata   = d;
            tick     = 1'($urandom_range(0, 1));
            dbg_halt = ($urandom_range(0, 3) == 0);
            step();
            wr_en = 1'b0;
            pick = $urandom_range(0, 24);
            if (pick < 16) a = 12'((pick / 4) * 32 + (pick % 4) * 4);
            else if (pick < 20) a = 12'h400 + 12'((pick - 16) * 4);
            else if (pick < 22) a = 12'h418 + 12'((pick - 20) * 4);
            else if (pick == 22) a = 12'hC00;
            else a = 12'h3FC;
            rd_model("rand_read", a);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wdt_reg_bank_mc.md
Name: wdt_reg_bank_mc

Overview:
Multi-channel watchdog register bank with NUM_CH independent down-counters, per-channel interrupt and reset generation, a global lock key, and test/stall control. It sits behind the APB slave decode, which supplies wr_en/rd_en strobes. It drives per-channel interrupt lines and a system-reset request to the reset controller. It is the parametrised successor of the single-channel WDT register bank: the counters live inside the block.

Parameters:
NUM_CH, 4, number of watchdog channels (1..8)
CNT_W, 32, counter/load width (8..32); registers zero-extend to 32 bits on read
LOCK_KEY, 32'h1ACC_E551, unlock key written to LOCK

Ports:
pclk  input  1  clock
presetn  input  1  reset; synchronous, active-low (sampled on rising pclk)
wr_en  input  1  APB write strobe (one cycle per access)
rd_en  input  1  APB read strobe
paddr  input  12  byte address
pwdata  input  32  write data
tick  input  1  count enable (prescaler strobe), common to all channels
dbg_halt  input  1  debugger halt request
prdata  output  32  read data
irq  output  NUM_CH  masked interrupt per channel (= MIS bits)
wdt_rst  output  1  one-cycle system-reset request pulse
lock  output  1  1 = register writes locked

Behaviour:
- Reset: all counters = {CNT_W{1}}; LOAD = {CNT_W{1}}; CTL = 0; RIS/MIS = 0; TEST = 0; CAUSE = 0; lock = 0; irq = 0; wdt_rst = 0; prdata = 0.
- Map (ch = 0..NUM_CH-1, base = ch*0x20):
  - base+0x0 LOAD (RW).
  - base+0x4 VALUE (RO).
  - base+0x8 CTL (RW): bit0 INTEN, bit1 RESEN.
  - base+0xC ICR (WO).
  - 0x400 RIS (RO, bit per channel); 0x404 MIS (RO).
  - 0x418 TEST: bit0 TEST, bit8 STALL.
  - 0x41C CAUSE (RO): bit per channel, set by reset request.
  - 0xC00 LOCK.
- Reads: prdata combinational; equals register when rd_en=1 and address mapped, else 0. Unmapped reads return 0, never X.
- LOCK write: pwdata==LOCK_KEY -> lock=0; any other value -> lock=1. Reads return {31'b0,lock}.
- While lock=1: writes to LOAD, CTL, ICR ignored. TEST writes update bit0 only; bit8 keeps its value.
- CTL.INTEN is sticky: once 1, only reset clears it. RESEN is freely writable.
- Counter runs when INTEN=1, tick=1, and not (STALL=1 and dbg_halt=1). Decrement by 1 per qualifying tick.
- LOAD write: counter reloads to pwdata[CNT_W-1:0] the next cycle. This overrides a same-cycle decrement or timeout. A write also clears the channel's RIS.
- Timeout: counter==0 with a qualifying tick.
  - Counter reloads from LOAD.
  - If RIS[ch]=1 already, RESEN=1 and TEST=0: wdt_rst pulses high for 1 cycle and CAUSE[ch] is set.
  - RIS[ch] is then set.
- MIS[ch] = RIS[ch] & INTEN[ch]; irq = MIS.
- ICR write (any data) clears RIS[ch]. If a timeout occurs in the same cycle, the timeout wins and RIS stays 1.
- LOAD=0: every qualifying tick is a timeout.
- CAUSE is cleared only by reset.
- Reset asserted mid-count: everything returns to reset values on that edge. No pulse is generated.

Optional Feature:
WDT_SLVERR_EN
- Defined: adds output pslverr (1 bit, combinational with the strobe). It asserts for any access to an unmapped address, a write to a RO register, or a write ignored due to lock.
- Undefined: no pslverr port; such accesses are silently ignored.

Decomposition:
- Package wdt_pkg:
  - offset constants (OFS_LOAD, OFS_VALUE, OFS_CTL, OFS_ICR, OFS_RIS, OFS_MIS, OFS_TEST, OFS_CAUSE, OFS_LOCK, CH_STRIDE);
  - DEFAULT LOCK_KEY;
  - CTL and TEST bit-position constants;
  - typedef ctl_t as a packed struct {resen, inten}.
- Sub-module wdt_channel (instantiated NUM_CH times):
  - holds counter, LOAD, CTL, RIS;
  - emits timeout and rst_req;
  - the top level does decode, lock, TEST, CAUSE and read muxing.

Test Plan:
- Reset -> read every mapped register: LOAD/VALUE=0xFFFFFFFF, all others 0. Unmapped 0x200 reads 0.
- ch1 LOAD=5, CTL=0x1, tick every cycle:
  - VALUE reaches 0 after 5 ticks;
  - the 6th tick sets RIS=0x2, irq[1]=1, and reloads to 5.
  - Writing ICR ch1 clears RIS.
- ch0 LOAD=2, CTL=0x3, no ICR: the first timeout sets RIS[0]. The second timeout gives a 1-cycle wdt_rst pulse and CAUSE=0x1. Repeating with TEST=1 gives no pulse.
- Write LOCK=0 (locks) -> LOAD ch2=0x10 is ignored and reads the old value. Write LOCK=0x1ACCE551 -> the same write takes effect.
- Write CTL=0x1 then CTL=0x0 -> INTEN stays 1. STALL=1 with dbg_halt=1 freezes VALUE; releasing dbg_halt resumes the count.
- Same-cycle ICR write and timeout on ch3 -> RIS[3] stays 1. Same-cycle LOAD write and tick -> VALUE equals the written value.
